// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Turns a MEM-stage load/store request from the datapath into a single
// registered request to the data memory, waits for the acknowledge (or a
// timeout), and returns lane-aligned, extended load data to the datapath.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   mreq_M, WRITE       : access request / store flag (held while stall=1)
//   alu_out_forMem      : byte address
//   rd2_forMem          : store data
//   size, sgn_ext_src   : 00 byte, 01 half, 1x word / sign-extend loads
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be : registered memory request
//   mem_rdata, mem_ack  : memory response
//   stall               : holds the pipeline while an access is in flight
//   DDT_from_mem        : load result
//   rdata_valid, bus_err, misalign : one-cycle completion status pulses
//
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of force-aligning them.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq_M,
    input  logic        WRITE,
    input  logic [31:0] alu_out_forMem,
    input  logic [31:0] rd2_forMem,
    input  logic [1:0]  size,
    input  logic        sgn_ext_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] DDT_from_mem,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    // Counter value seen in the last BUSY cycle before a timeout fires.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] ddt_q, ddt_d;
    logic        rvalid_q, rvalid_d;
    logic        berr_q, berr_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;

    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction
`endif

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return a;
            2'b01:   return {a[31:1], 1'b0};
            default: return {a[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        ddt_d       = ddt_q;
        rvalid_d    = 1'b0;
        berr_d      = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mreq_M) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (is_misaligned(alu_out_forMem[1:0], size)) begin
                        // Trapped access never reaches memory.
                        state_d = DONE;
                        mis_d   = 1'b1;
                        ddt_d   = '0;
                    end else
`endif
                    begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        size_d      = size;
                        sgn_d       = sgn_ext_src;
                        mem_req_d   = 1'b1;
                        mem_we_d    = WRITE;
                        mem_addr_d  = align_addr(alu_out_forMem, size);
                        mem_wdata_d = lane_wdata(rd2_forMem, size);
                        mem_be_d    = lane_be(alu_out_forMem[1:0], size);
                    end
                end
            end
            BUSY: begin
                // An ack on the timeout cycle itself still completes normally.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        ddt_d    = load_extract(mem_rdata, mem_addr_q[1:0], size_q, sgn_q);
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    cnt_d     = cnt_q + 8'd1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    berr_d    = 1'b1;
                    ddt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            ddt_q       <= '0;
            rvalid_q    <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            ddt_q       <= ddt_d;
            rvalid_q    <= rvalid_d;
            berr_q      <= berr_d;
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= mis_d;
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign stall        = ((state_q == IDLE) && mreq_M) || (state_q == BUSY);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign DDT_from_mem = ddt_q;
    assign rdata_valid  = rvalid_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq_M, WRITE, sgn_ext_src, mem_ack;
    logic [31:0] alu_out_forMem, rd2_forMem, mem_rdata;
    logic [1:0]  size;
    logic        mem_req, mem_we, stall, rdata_valid, bus_err, misalign;
    logic [31:0] mem_addr, mem_wdata, DDT_from_mem;
    logic [3:0]  mem_be;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_ddt;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_req_seen;
    int          obs_stall;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mreq_M(mreq_M), .WRITE(WRITE),
        .alu_out_forMem(alu_out_forMem), .rd2_forMem(rd2_forMem),
        .size(size), .sgn_ext_src(sgn_ext_src),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .DDT_from_mem(DDT_from_mem),
        .rdata_valid(rdata_valid), .bus_err(bus_err), .misalign(misalign)
    );

    // Reference model: byte-lane rules expressed with plain arithmetic.
    function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return a;
        if (sz == 2'b01) return a - (a % 2);
        return a - (a % 4);
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 4'(1 << (a % 4));
        if (sz == 2'b01) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One complete access; ack_dly = index of the BUSY cycle carrying mem_ack
    // (>= TIMEOUT means never). hold keeps mreq_M high through DONE.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic sx, input logic [31:0] rd,
                             input int ack_dly, input bit hold);
        logic trap, tmo, done;
        int exp_stall, busy;
        trap = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        trap = (sz == 2'b01 && a % 2 != 0) || (sz[1] && a % 4 != 0);
`endif
        tmo = !trap && (ack_dly >= TIMEOUT);
        exp_stall = trap ? 1 : (tmo ? 1 + TIMEOUT : 2 + ack_dly);
        if (trap || tmo) exp_ddt = '0;
        else if (!wr)    exp_ddt = ref_load(rd, a, sz, sx);
        obs_req_seen = 1'b0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;

        @(negedge clk);
        mreq_M = 1'b1; WRITE = wr; alu_out_forMem = a; rd2_forMem = d;
        size = sz; sgn_ext_src = sx; mem_rdata = rd; mem_ack = 1'b0;
        #1;
        obs_stall = 0; busy = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                obs_stall++;
                vectors++;
                if (mem_req !== (obs_stall > 1)) begin
                    miscompares++;
                    $display("FAIL mem_req cyc%0d: got %b expected %b", obs_stall, mem_req, obs_stall > 1);
                end
                if (mem_req === 1'b1) begin
                    if (!obs_req_seen) begin
                        obs_req_seen = 1'b1; obs_addr = mem_addr; obs_wdata = mem_wdata;
                        obs_be = mem_be; obs_we = mem_we;
                    end
                    vectors++;
                    if (mem_addr !== ref_addr(a, sz) || mem_be !== ref_be(a, sz) ||
                        mem_we !== wr || (wr && mem_wdata !== ref_wdata(d, sz))) begin
                        miscompares++;
                        $display("FAIL req_fields a=%h sz=%0d: got addr=%h be=%b we=%b wd=%h expected addr=%h be=%b we=%b wd=%h",
                                 a, sz, mem_addr, mem_be, mem_we, mem_wdata,
                                 ref_addr(a, sz), ref_be(a, sz), wr, ref_wdata(d, sz));
                    end
                    mem_ack = (busy == ack_dly);
                    busy++;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL access_bound: stall still high after 64 cycles, expected %0d", exp_stall);
        end
        if (!hold) mreq_M = 1'b0;
        #1;
        vectors++;
        if (obs_stall != exp_stall) begin
            miscompares++;
            $display("FAIL stall_len: got %0d expected %0d", obs_stall, exp_stall);
        end
        vectors++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ctl: got stall=%b req=%b we=%b expected 0 0 0", stall, mem_req, mem_we);
        end
        vectors++;
        if (bus_err !== tmo || misalign !== trap) begin
            miscompares++;
            $display("FAIL done_status: got berr=%b mis=%b expected %b %b", bus_err, misalign, tmo, trap);
        end
        if (!tmo) begin
            vectors++;
            if (rdata_valid !== (!wr && !trap)) begin
                miscompares++;
                $display("FAIL rdata_valid: got %b expected %b", rdata_valid, !wr && !trap);
            end
        end
        vectors++;
        if (DDT_from_mem !== exp_ddt) begin
            miscompares++;
            $display("FAIL ddt: got %h expected %h", DDT_from_mem, exp_ddt);
        end
        @(negedge clk); #1;
        if (hold) begin
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_stall_after_hold: got %b expected 1", stall);
            end
            mreq_M = 1'b0;
            @(negedge clk); #1;
        end
        vectors++;
        if (rdata_valid !== 1'b0 || bus_err !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0 ||
            mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_end: got rv=%b berr=%b mis=%b stall=%b req=%b expected all 0",
                     rdata_valid, bus_err, misalign, stall, mem_req);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mem_be !== 4'h0 || DDT_from_mem !== 32'h0 || rdata_valid !== 1'b0 ||
            bus_err !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b addr=%h be=%b ddt=%h stall=%b expected all 0",
                     mem_req, mem_addr, mem_be, DDT_from_mem, stall);
        end
        mreq_M = 1'b1; #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle_stall: got %b expected 1", stall);
        end
        mreq_M = 1'b0;
        exp_ddt = '0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_load_byte_sext();
        do_access(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 32'h80FF_1234, 0, 1'b0);
        vectors++;
        if (obs_be !== 4'b1000 || DDT_from_mem !== 32'hFFFF_FF80 || obs_stall != 2) begin
            miscompares++;
            $display("FAIL load_byte_sext: got be=%b ddt=%h stall=%0d expected 1000 ffffff80 2",
                     obs_be, DDT_from_mem, obs_stall);
        end
    endtask

    task automatic test_store_half();
        do_access(1'b1, 32'h0000_0202, 32'h1234_ABCD, 2'b01, 1'b0, 32'h5555_5555, 3, 1'b0);
        vectors++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_stall != 5) begin
            miscompares++;
            $display("FAIL store_half: got we=%b be=%b wd=%h stall=%0d expected 1 1100 abcdabcd 5",
                     obs_we, obs_be, obs_wdata, obs_stall);
        end
    endtask

    task automatic test_timeout();
        do_access(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1000, 1'b0);
        vectors++;
        if (DDT_from_mem !== 32'h0 || obs_stall != 1 + TIMEOUT || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: got ddt=%h stall=%0d req=%b expected 0 %0d 0",
                     DDT_from_mem, obs_stall, mem_req, 1 + TIMEOUT);
        end
    endtask

    task automatic test_misalign_word();
        do_access(1'b0, 32'h0000_0106, 32'h0, 2'b10, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
        vectors++;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (obs_req_seen !== 1'b0 || obs_stall != 1) begin
            miscompares++;
            $display("FAIL misalign_trap: got req_seen=%b stall=%0d expected 0 1", obs_req_seen, obs_stall);
        end
`else
        if (obs_addr !== 32'h0000_0104 || obs_be !== 4'hF) begin
            miscompares++;
            $display("FAIL misalign_align: got addr=%h be=%b expected 00000104 1111", obs_addr, obs_be);
        end
`endif
    endtask

    task automatic test_done_ignores_mreq();
        do_access(1'b0, 32'h0000_0311, 32'h0, 2'b01, 1'b1, 32'h0000_8001, 1, 1'b1);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        mreq_M = 1'b1; WRITE = 1'b0; alu_out_forMem = 32'h0000_0400; size = 2'b10; mem_ack = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy_req: got %b expected 1", mem_req);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got req=%b addr=%h stall=%b expected 0 0 1", mem_req, mem_addr, stall);
        end
        mreq_M = 1'b0;
        exp_ddt = '0;
        @(negedge clk); rst = 1'b1;
        do_access(1'b0, 32'h0000_0402, 32'h0, 2'b01, 1'b0, 32'hCAFE_1234, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5),
                      ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst = 1'b0; mreq_M = 1'b0; WRITE = 1'b0; alu_out_forMem = '0; rd2_forMem = '0;
        size = '0; sgn_ext_src = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        exp_ddt = '0;
        test_reset();
        test_load_byte_sext();
        test_store_half();
        test_timeout();
        test_misalign_word();
        test_done_ignores_mreq();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
